// File: rtl/ram_responder.sv
// Word-addressed RAM responder with a main region at the bottom of the address map and a
// downward-growing stack region at the top; zero-fills both arrays after every reset.
module ram_responder #(
    parameter int MAIN_WORDS  = 4096,
    parameter int STACK_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_rd_en,
    input  logic        ram_wr_en,
    input  logic [23:0] ram_addr,
    input  logic [15:0] ram_wr_data,
    output logic [15:0] ram_rd_data,
    output logic        ram_busy,
    output logic        ram_err,
    output logic [7:0]  err_count,
    input  logic        err_clr
);

    localparam int DATA_W   = 16;
    localparam int MAIN_AW  = (MAIN_WORDS  > 1) ? $clog2(MAIN_WORDS)  : 1;
    localparam int STACK_AW = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;

    localparam logic [16:0]        MAIN_LIM       = 17'(MAIN_WORDS);
    localparam logic [16:0]        STACK_LIM      = 17'(STACK_WORDS);
    localparam logic [MAIN_AW:0]   INIT_STACK_LIM = (MAIN_AW + 1)'(STACK_WORDS);
    localparam logic [MAIN_AW-1:0] INIT_LAST      = MAIN_AW'(MAIN_WORDS - 1);

    localparam logic [0:0] STATE_INIT  = 1'b0;
    localparam logic [0:0] STATE_READY = 1'b1;

    logic [0:0]          state;
    logic [MAIN_AW-1:0]  init_ptr;
    logic [DATA_W-1:0]   main_mem  [MAIN_WORDS];
    logic [DATA_W-1:0]   stack_mem [STACK_WORDS];

    logic [15:0]         stack_off;
    logic                main_hit;
    logic                stack_hit;
    logic [MAIN_AW-1:0]  main_idx;
    logic [STACK_AW-1:0] stack_idx;
    logic                ready;
    logic                bad_p0;
    logic                init_stack;
    logic [DATA_W-1:0]   rd_data_p1;
    logic                err_flag;
    logic [7:0]          err_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stack addresses count down from 0xFFFFFF, so the index is the bitwise distance from the top.
    assign stack_off  = 16'hFFFF - ram_addr[15:0];
    assign main_hit   = (ram_addr[23:16] == 8'h00) && ({1'b0, ram_addr[15:0]} < MAIN_LIM);
    assign stack_hit  = (ram_addr[23:16] == 8'hFF) && ({1'b0, stack_off} < STACK_LIM);
    assign main_idx   = ram_addr[MAIN_AW-1:0];
    assign stack_idx  = stack_off[STACK_AW-1:0];
    assign ready      = (state == STATE_READY);
    assign bad_p0     = ready && (ram_rd_en || ram_wr_en) && !(main_hit || stack_hit);
    assign init_stack = ({1'b0, init_ptr} < INIT_STACK_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= STATE_INIT;
            init_ptr <= '0;
        end else if (state == STATE_INIT) begin
            init_ptr <= init_ptr + MAIN_AW'(1);
            if (init_ptr == INIT_LAST)
                state <= STATE_READY;
        end
    end

    // Array contents carry no reset; the INIT sweep establishes zeros.
    always_ff @(posedge clk) begin
        if (state == STATE_INIT) begin
            main_mem[init_ptr] <= '0;
            if (init_stack)
                stack_mem[init_ptr[STACK_AW-1:0]] <= '0;
        end else if (ram_wr_en) begin
            if (main_hit)
                main_mem[main_idx] <= ram_wr_data;
            if (stack_hit)
                stack_mem[stack_idx] <= ram_wr_data;
        end
    end

    // Stage p1: registered read data, write-first when both enables hit the same word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_p1 <= '0;
        end else if (ready && ram_rd_en) begin
            if (main_hit)
                rd_data_p1 <= ram_wr_en ? ram_wr_data : main_mem[main_idx];
            else if (stack_hit)
                rd_data_p1 <= ram_wr_en ? ram_wr_data : stack_mem[stack_idx];
            else
                rd_data_p1 <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else if (bad_p0) begin
            err_flag <= 1'b1;
            err_cnt  <= err_clr ? 8'd1 : sat_inc(err_cnt);
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end
    end

    assign ram_rd_data = rd_data_p1;
    assign ram_busy    = (state == STATE_INIT);
    assign ram_err     = err_flag;
    assign err_count   = err_cnt;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_rd_en, ram_wr_en, err_clr;
    logic [23:0] ram_addr;
    logic [15:0] ram_wr_data;
    logic [15:0] ram_rd_data;
    logic        ram_busy, ram_err;
    logic [7:0]  err_count;

    ram_responder #(.MAIN_WORDS(16), .STACK_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data), .ram_busy(ram_busy),
        .ram_err(ram_err), .err_count(err_count), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] d;
        logic        e;
        logic [7:0]  c;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_rd;
    logic        m_err;
    logic [7:0]  m_cnt;

    always @(posedge clk) cyc++;

    // Monitor: each expectation becomes due one cycle after its request was driven.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            if (sb[0].due < cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", sb[0].nm, sb[0].due, cyc);
            end else if (ram_rd_data !== sb[0].d || ram_err !== sb[0].e ||
                         err_count !== sb[0].c || ram_busy !== 1'b0) begin
                failures++;
                $display("FAIL %s: got rd=%h err=%b cnt=%h busy=%b, want rd=%h err=%b cnt=%h busy=0",
                         sb[0].nm, ram_rd_data, ram_err, err_count, ram_busy, sb[0].d, sb[0].e, sb[0].c);
            end
            void'(sb.pop_front());
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", nm, act, want);
        end
    endtask

    // One request cycle; exp_rd is the hand-computed read result, bad marks an out-of-range access.
    task automatic issue(input string nm, input bit rd, input bit wr, input bit clr,
                         input logic [23:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input bit bad);
        exp_t x;
        ram_rd_en = rd; ram_wr_en = wr; err_clr = clr;
        ram_addr = a; ram_wr_data = wd;
        if (rd) m_rd = exp_rd;
        if (bad) begin
            m_err = 1'b1;
            m_cnt = clr ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
        end else if (clr) begin
            m_err = 1'b0;
            m_cnt = 8'd0;
        end
        x.due = cyc + 1; x.d = m_rd; x.e = m_err; x.c = m_cnt; x.nm = nm;
        sb.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        ram_rd_en = 0; ram_wr_en = 0; err_clr = 0; ram_addr = '0; ram_wr_data = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_rd"}, 32'(ram_rd_data), 32'h0);
        chk({nm, "_busy"}, 32'(ram_busy), 32'h1);
        chk({nm, "_err"}, 32'(ram_err), 32'h0);
        chk({nm, "_cnt"}, 32'(err_count), 32'h0);
        m_rd = '0; m_err = 1'b0; m_cnt = '0;
    endtask

    // Counts busy cycles after release while hammering requests that INIT must ignore.
    task automatic count_busy(input string nm);
        int n = 0;
        ram_rd_en = 1; ram_wr_en = 1; ram_addr = 24'h000002; ram_wr_data = 16'hFFFF;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ram_busy) n++;
            else break;
        end
        idle_inputs();
        chk(nm, 32'(n), 32'd16);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs("reset0");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        count_busy("busy_len0");

        issue("rd_init_zero", 1, 0, 0, 24'h000005, 16'h0, 16'h0000, 0);
        issue("wr_a", 0, 1, 0, 24'h00000A, 16'hBEEF, 16'h0, 0);
        issue("rd_a_after_wr", 1, 0, 0, 24'h00000A, 16'h0, 16'hBEEF, 0);
        issue("wr_stack_top", 0, 1, 0, 24'hFFFFFF, 16'h00AB, 16'h0, 0);
        issue("rd_stack_top", 1, 0, 0, 24'hFFFFFF, 16'h0, 16'h00AB, 0);
        issue("rd_main0", 1, 0, 0, 24'h000000, 16'h0, 16'h0000, 0);
        issue("rd_stack1", 1, 0, 0, 24'hFFFFFE, 16'h0, 16'h0000, 0);
        issue("rdwr_same", 1, 1, 0, 24'h000003, 16'h1234, 16'h1234, 0);
        issue("wr_main_last", 0, 1, 0, 24'h00000F, 16'h5A5A, 16'h0, 0);
        issue("rd_main_last", 1, 0, 0, 24'h00000F, 16'h0, 16'h5A5A, 0);
        issue("idle_hold", 0, 0, 0, 24'h000003, 16'h0, 16'h0, 0);
        issue("wr_oor_main", 0, 1, 0, 24'h000010, 16'h1111, 16'h0, 1);
        issue("rd_oor_main", 1, 0, 0, 24'h000010, 16'h0, 16'h0000, 1);
        issue("rdwr_oor_once", 1, 1, 0, 24'h000010, 16'h2222, 16'h0000, 1);
        issue("wr_stack_last", 0, 1, 0, 24'hFFFFF8, 16'h7777, 16'h0, 0);
        issue("rd_stack_last", 1, 0, 0, 24'hFFFFF8, 16'h0, 16'h7777, 0);
        issue("rd_oor_stack", 1, 0, 0, 24'hFFFFF7, 16'h0, 16'h0000, 1);
        issue("rd_oor_upper", 1, 0, 0, 24'h010000, 16'h0, 16'h0000, 1);
        issue("rd_main_intact", 1, 0, 0, 24'h00000F, 16'h0, 16'h5A5A, 0);
        issue("rd_main3", 1, 0, 0, 24'h000003, 16'h0, 16'h1234, 0);
        issue("err_clr", 0, 0, 1, 24'h000000, 16'h0, 16'h0, 0);
        for (int i = 0; i < 300; i++)
            issue("oor_saturate", 1, 0, 0, 24'h123456, 16'h0, 16'h0000, 1);
        issue("clr_with_err", 1, 0, 1, 24'h123456, 16'h0, 16'h0000, 1);
        issue("rd_a_again", 1, 0, 0, 24'h00000A, 16'h0, 16'hBEEF, 0);
        idle_inputs();
        drain();

        rst = 1'b0;
        #1;
        check_reset_outputs("reset_ready");
        @(posedge clk); #1 rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("init_ptr7_busy", 32'(ram_busy), 32'h1);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_init7");
        @(posedge clk); #1 rst = 1'b1;
        count_busy("busy_len_restart");

        issue("rd_a_rezeroed", 1, 0, 0, 24'h00000A, 16'h0, 16'h0000, 0);
        issue("rd_init_ignored", 1, 0, 0, 24'h000002, 16'h0, 16'h0000, 0);
        issue("rd_stack_rezeroed", 1, 0, 0, 24'hFFFFFF, 16'h0, 16'h0000, 0);
        idle_inputs();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 The module SHALL have parameter MAIN_WORDS, default 4096, giving the depth of the main-region array (power of two).
REQ-002 The module SHALL have parameter STACK_WORDS, default 256, giving the depth of the stack-region array (power of two, not greater than MAIN_WORDS).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port ram_rd_en, input, 1 bit: read request for this cycle.
REQ-006 The module SHALL have port ram_wr_en, input, 1 bit: write request for this cycle.
REQ-007 The module SHALL have port ram_addr, input, 24 bits: request address.
REQ-008 The module SHALL have port ram_wr_data, input, 16 bits: write data.
REQ-009 The module SHALL have port ram_rd_data, output, 16 bits: registered read data.
REQ-010 The module SHALL have port ram_busy, output, 1 bit: high while memory initialisation runs.
REQ-011 The module SHALL have port ram_err, output, 1 bit: sticky out-of-range access flag.
REQ-012 The module SHALL have port err_count, output, 8 bits: saturating count of out-of-range accesses.
REQ-013 The module SHALL have port err_clr, input, 1 bit: synchronous clear of ram_err and err_count.

Function
REQ-014 Address decode SHALL be: main region when ram_addr[23:16]==8'h00 and ram_addr[15:0]<MAIN_WORDS; stack region when ram_addr[23:16]==8'hFF and (16'hFFFF-ram_addr[15:0])<STACK_WORDS, stack index = 16'hFFFF-ram_addr[15:0]; otherwise out-of-range.
REQ-015 The FSM SHALL have states INIT and READY; reset forces INIT with init pointer 0.
REQ-016 In INIT, each cycle SHALL write 16'h0000 to index init_ptr of both arrays (stack only while init_ptr<STACK_WORDS), then increment init_ptr.
REQ-017 INIT SHALL transition to READY on the edge that writes index MAIN_WORDS-1, so ram_busy is high for exactly MAIN_WORDS cycles after reset release.
REQ-018 In INIT, requests SHALL be ignored: no array write, ram_rd_data unchanged, no error counted.
REQ-019 In READY, ram_wr_en with an in-range address SHALL update the addressed word at the end of the request cycle.
REQ-020 In READY, ram_rd_en with an in-range address in cycle N SHALL present the word on ram_rd_data in cycle N+1, holding it until the next accepted read.
REQ-021 A read in cycle N+1 of an address written in cycle N SHALL return the new data.
REQ-022 ram_rd_en and ram_wr_en together to an in-range address SHALL write, and ram_rd_data in N+1 SHALL equal ram_wr_data (write-first).
REQ-023 Out-of-range write SHALL be dropped; out-of-range read SHALL load 16'h0000 into ram_rd_data; either SHALL set ram_err and increment err_count (one count per cycle even if both enables high).
REQ-024 err_count SHALL saturate at 8'hFF.
REQ-025 err_clr SHALL clear ram_err and err_count at the edge; an error in the same cycle SHALL win: ram_err=1, err_count=1.

Reset
REQ-026 While rst is low: ram_rd_data=16'h0000, ram_busy=1, ram_err=0, err_count=0, state INIT, init_ptr=0, taking effect immediately without a clock edge.
REQ-027 rst asserted mid-operation, including during INIT, SHALL abort and restart initialisation from index 0 on release.
REQ-028 Array contents SHALL not be reset asynchronously; INIT SHALL establish zeros.

Verification
REQ-029 Release reset with MAIN_WORDS=16 -> ram_busy high 16 cycles then low; a read of 0x000005 returns 0x0000.
REQ-030 Write 0x00000A=0xBEEF in cycle N, read the same address in N+1 -> ram_rd_data=0xBEEF in N+2.
REQ-031 Write 0xFFFFFF=0x00AB, then read 0xFFFFFF; read 0x000000 -> 0x00AB returned for 0xFFFFFF only; the main array is unaffected.
REQ-032 Write 0x000003=0x1234 with ram_rd_en also high -> ram_rd_data=0x1234 next cycle.
REQ-033 Read 0x123456 ×300 -> ram_rd_data=0, ram_err=1, err_count=0xFF; err_clr with a simultaneous bad read -> err_count=1.
REQ-034 Pulse rst low during INIT at init_ptr=7 -> outputs reset at once; ram_busy high a full MAIN_WORDS cycles after release.
